// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - decode-side bundle between the decode stage and the hazard unit
interface hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int NSRC  = 2,
    parameter int CNT_W = 16
) ();
    logic                    id_valid;
    logic [NSRC*REG_W-1:0]   id_rs;
    logic [NSRC-1:0]         id_rs_used;
    logic [REG_W-1:0]        id_rd;
    logic                    id_regwrite;
    logic                    id_isload;
    logic                    id_isbranch;
    logic                    flush;
    logic                    cnt_clear;
    logic                    stall;
    logic [NSRC*2-1:0]       fwd_sel;
    logic [CNT_W-1:0]        stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_isload, id_isbranch,
        output flush, cnt_clear,
        input  stall, fwd_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_isload, id_isbranch,
        input  flush, cnt_clear,
        output stall, fwd_sel, stall_count
    );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - decode-stage hazard detection and registered forwarding selects
module hazard_unit #(
    parameter int REG_W     = 5,
    parameter int NSRC      = 2,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             load;
    } slot_t;

    slot_t             s1, s2, s3;
    logic              hazard;
    logic              issue;
    logic [NSRC*2-1:0] cand;
    logic [NSRC*2-1:0] fwd_q;
    logic [CNT_W-1:0]  cnt_q;

    function automatic logic hit(input slot_t s, input logic [REG_W-1:0] rs);
        return s.valid && s.wr && (s.rd == rs);
    endfunction

    // Youngest producer wins; a WB-slot match never stalls, even for branches.
    always_comb begin
        hazard = 1'b0;
        cand   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (hz.id_rs_used[i] && (hz.id_rs[i*REG_W +: REG_W] != '0)) begin
                if (hit(s1, hz.id_rs[i*REG_W +: REG_W])) begin
                    if (s1.load || hz.id_isbranch) hazard = 1'b1;
                    else                           cand[i*2 +: 2] = 2'd1;
                end else if (hit(s2, hz.id_rs[i*REG_W +: REG_W])) begin
                    if (hz.id_isbranch) hazard = 1'b1;
                    else                cand[i*2 +: 2] = 2'd2;
                end else if (hit(s3, hz.id_rs[i*REG_W +: REG_W])) begin
                    cand[i*2 +: 2] = (WB_BYPASS != 0) ? 2'd3 : 2'd0;
                end
            end
        end
    end

    assign hz.stall       = hz.id_valid & ~hz.flush & hazard;
    assign issue          = hz.id_valid & ~hz.flush & ~hazard;
    assign hz.fwd_sel     = fwd_q;
    assign hz.stall_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            fwd_q <= '0;
            cnt_q <= '0;
        end else begin
            s3    <= s2;
            s2    <= s1;
            s1    <= issue ? {1'b1, hz.id_rd, hz.id_regwrite, hz.id_isload} : '0;
            fwd_q <= issue ? cand : '0;
            if (hz.cnt_clear)
                cnt_q <= '0;
            else if (hz.stall && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit against a pipeline-history model
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, wr, ld, br, flush, clr;
    logic [4:0] rs0, rs1, rd;
    logic [1:0] used;

    hazard_unit_if                 hz0 ();
    hazard_unit_if #(.CNT_W(2))    hz1 ();

    assign hz0.id_valid = id_valid;  assign hz1.id_valid = id_valid;
    assign hz0.id_rs = {rs1, rs0};   assign hz1.id_rs = {rs1, rs0};
    assign hz0.id_rs_used = used;    assign hz1.id_rs_used = used;
    assign hz0.id_rd = rd;           assign hz1.id_rd = rd;
    assign hz0.id_regwrite = wr;     assign hz1.id_regwrite = wr;
    assign hz0.id_isload = ld;       assign hz1.id_isload = ld;
    assign hz0.id_isbranch = br;     assign hz1.id_isbranch = br;
    assign hz0.flush = flush;        assign hz1.flush = flush;
    assign hz0.cnt_clear = clr;      assign hz1.cnt_clear = clr;

    hazard_unit dut0 (.clk(clk), .rst_n(rst_n), .hz(hz0));
    hazard_unit #(.WB_BYPASS(0), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .hz(hz1));

    // Model: the last three instructions that left decode, index 0 = now in EX.
    typedef struct { bit v; bit [4:0] rd; bit wr; bit ld; } instr_t;
    instr_t     hist [3];
    logic [3:0] exp_fwd0, exp_fwd1;
    int         exp_cnt0, exp_cnt1;
    int         passed = 0;
    int         total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
        exp_fwd0 = 0; exp_fwd1 = 0; exp_cnt0 = 0; exp_cnt1 = 0;
    endtask

    task automatic model_eval(input bit bypass, output bit st, output logic [3:0] sel);
        bit         hzd;
        logic [4:0] rs;
        int         k;
        hzd = 0; sel = 0;
        for (int i = 0; i < 2; i++) begin
            rs = (i == 0) ? rs0 : rs1;
            k = -1;
            if (used[i] && rs != 0)
                for (int j = 2; j >= 0; j--)
                    if (hist[j].v && hist[j].wr && hist[j].rd == rs) k = j;
            case (k)
                0: if (hist[0].ld || br) hzd = 1; else sel[i*2 +: 2] = 2'd1;
                1: if (br) hzd = 1; else sel[i*2 +: 2] = 2'd2;
                2: sel[i*2 +: 2] = bypass ? 2'd3 : 2'd0;
                default: ;
            endcase
        end
        st = id_valid && !flush && hzd;
    endtask

    task automatic step();
        bit         st;
        bit         issue;
        logic [3:0] s0, s1;
        #1;
        model_eval(1'b1, st, s0);
        model_eval(1'b0, st, s1);
        check("stall0", hz0.stall, st);
        check("stall1", hz1.stall, st);
        check("fwd0", hz0.fwd_sel, exp_fwd0);
        check("fwd1", hz1.fwd_sel, exp_fwd1);
        check("cnt0", hz0.stall_count, exp_cnt0);
        check("cnt1", hz1.stall_count, exp_cnt1);
        issue = id_valid && !flush && !st;
        @(posedge clk);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = issue ? '{1, rd, wr, ld} : '{0, 0, 0, 0};
        exp_fwd0 = issue ? s0 : 4'd0;
        exp_fwd1 = issue ? s1 : 4'd0;
        if (clr) begin
            exp_cnt0 = 0; exp_cnt1 = 0;
        end else if (st) begin
            if (exp_cnt0 < 65535) exp_cnt0++;
            if (exp_cnt1 < 3) exp_cnt1++;
        end
        #1;
    endtask

    task automatic set_instr(input bit v, input logic [4:0] a, input logic [4:0] b,
                             input logic [1:0] u, input logic [4:0] d,
                             input bit w, input bit l, input bit bb);
        id_valid = v; rs0 = a; rs1 = b; used = u; rd = d; wr = w; ld = l; br = bb;
        flush = 0; clr = 0;
    endtask

    initial begin
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // ALU producer then consumer: forward from EX/MEM
        set_instr(1, 0, 0, 2'b00, 3, 1, 0, 0); step();
        set_instr(1, 3, 0, 2'b01, 6, 1, 0, 0); step();
        check("alu_fwd", hz0.fwd_sel[1:0], 2'd1);

        // Load-use: one stall, then select 2
        set_instr(1, 0, 0, 2'b00, 4, 1, 1, 0); step();
        set_instr(1, 0, 4, 2'b10, 8, 1, 0, 0); step(); step();
        check("load_fwd", hz0.fwd_sel[3:2], 2'd2);
        check("load_cnt", hz0.stall_count, 32'd1);

        // ALU then branch: two stalls
        set_instr(1, 0, 0, 2'b00, 5, 1, 0, 0); step();
        set_instr(1, 5, 0, 2'b01, 0, 0, 0, 1); step(); step(); step();
        check("br_cnt", hz0.stall_count, 32'd3);

        // WB-slot producer
        set_instr(1, 0, 0, 2'b00, 7, 1, 0, 0); step();
        set_instr(1, 0, 0, 2'b00, 0, 0, 0, 0); step(); step();
        set_instr(1, 7, 0, 2'b01, 9, 1, 0, 0); step();
        check("wb_bypass", hz0.fwd_sel[1:0], 2'd3);
        check("wb_nobypass", hz1.fwd_sel[1:0], 2'd0);

        // r0 and non-writing producers never match
        set_instr(1, 0, 0, 2'b00, 0, 1, 1, 0); step();
        set_instr(1, 0, 0, 2'b11, 10, 1, 0, 0); step();
        check("r0_fwd", hz0.fwd_sel, 4'd0);
        set_instr(1, 0, 0, 2'b00, 9, 0, 1, 0); step();
        set_instr(1, 9, 9, 2'b11, 11, 1, 0, 0); step();
        check("nowr_fwd", hz0.fwd_sel, 4'd0);

        // Flush beats a pending load-use
        set_instr(1, 0, 0, 2'b00, 4, 1, 1, 0); step();
        set_instr(1, 4, 0, 2'b01, 12, 1, 0, 0); flush = 1; step();

        for (int n = 0; n < 400; n++) begin
            set_instr($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      2'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 99) < 80,
                      $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20);
            flush = $urandom_range(0, 99) < 5;
            clr   = $urandom_range(0, 99) < 3;
            step();
        end

        // Saturation: six stalls after a clear
        set_instr(0, 0, 0, 2'b00, 0, 0, 0, 0); clr = 1; step();
        repeat (3) begin
            set_instr(1, 0, 0, 2'b00, 4, 1, 1, 0); step();
            set_instr(1, 4, 0, 2'b01, 0, 0, 0, 1); step(); step(); step();
        end
        check("sat_cnt1", hz1.stall_count, 32'd3);
        check("sat_cnt0", hz0.stall_count, 32'd6);

        // Asynchronous reset in the middle of a stall
        set_instr(1, 0, 0, 2'b00, 4, 1, 1, 0); step();
        set_instr(1, 0, 4, 2'b10, 13, 1, 0, 0);
        #2;
        check("pre_rst_stall", hz0.stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_stall", hz0.stall, 1'b0);
        check("rst_fwd", hz0.fwd_sel, 4'd0);
        check("rst_cnt", hz0.stall_count, 32'd0);
        check("rst_cnt1", hz1.stall_count, 32'd0);
        model_reset();
        set_instr(0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
